// File: rtl/riscv_pkg.sv
// Shared funct3 encodings and the load/store unit state type.
package riscv_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational access shaping: legality, byte enables, store lane steering
// and load lane extraction with sign/zero extension.
module lsu_align
   import riscv_pkg::*;
(
   input  logic        req_is_load,
   input  logic [2:0]  req_funct3,
   input  logic [1:0]  req_addr_lo,
   input  logic [31:0] req_wdata,
   output logic        req_legal,
   output logic [3:0]  req_be,
   output logic [31:0] req_wdata_lane,
   input  logic        rsp_is_load,
   input  logic [2:0]  rsp_funct3,
   input  logic [1:0]  rsp_addr_lo,
   input  logic [31:0] rsp_rdata,
   output logic [31:0] rsp_data
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   always_comb begin
      req_legal = 1'b0;
      case (req_funct3)
         F3_LB:   req_legal = 1'b1;
         F3_LH:   req_legal = ~req_addr_lo[0];
         F3_LW:   req_legal = (req_addr_lo == 2'b00);
         F3_LBU:  req_legal = req_is_load;
         F3_LHU:  req_legal = req_is_load & ~req_addr_lo[0];
         default: req_legal = 1'b0;
      endcase
   end

   // Width is encoded in funct3[1:0] for both signed and unsigned forms.
   always_comb begin
      req_be         = 4'b1111;
      req_wdata_lane = req_wdata;
      case (req_funct3[1:0])
         2'b00: begin
            req_be         = 4'b0001 << req_addr_lo;
            req_wdata_lane = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            req_be         = 4'b0011 << {req_addr_lo[1], 1'b0};
            req_wdata_lane = {2{req_wdata[15:0]}};
         end
         default: begin
            req_be         = 4'b1111;
            req_wdata_lane = req_wdata;
         end
      endcase
   end

   always_comb begin
      case (rsp_addr_lo)
         2'd0:    byte_lane = rsp_rdata[7:0];
         2'd1:    byte_lane = rsp_rdata[15:8];
         2'd2:    byte_lane = rsp_rdata[23:16];
         default: byte_lane = rsp_rdata[31:24];
      endcase
      half_lane = rsp_addr_lo[1] ? rsp_rdata[31:16] : rsp_rdata[15:0];
   end

   always_comb begin
      rsp_data = 32'h0;
      if (rsp_is_load) begin
         case (rsp_funct3)
            F3_LB:   rsp_data = {{24{byte_lane[7]}}, byte_lane};
            F3_LH:   rsp_data = {{16{half_lane[15]}}, half_lane};
            F3_LW:   rsp_data = rsp_rdata;
            F3_LBU:  rsp_data = {24'h0, byte_lane};
            F3_LHU:  rsp_data = {16'h0, half_lane};
            default: rsp_data = 32'h0;
         endcase
      end
   end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: accepts loads/stores from execute, runs one req/ack
// transaction on the data-memory port and returns extended load data.
//
// state | meaning
// IDLE  | waiting for an accepted access; illegal ones pulse err_o only
// BUSY  | request outstanding on dmem, all dmem_* outputs held
// DONE  | one-cycle completion, rdata_o/rd_o valid, upstream released
module load_store_unit
   import riscv_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        valid_i,
   input  logic        mem_read_i,
   input  logic        mem_write_i,
   input  logic [2:0]  funct3_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   input  logic [4:0]  rd_i,
   output logic        stall_o,
   output logic        done_o,
   output logic [31:0] rdata_o,
   output logic [4:0]  rd_o,
   output logic        err_o,
   output logic        dmem_req_o,
   output logic        dmem_we_o,
   output logic [31:0] dmem_addr_o,
   output logic [31:0] dmem_wdata_o,
   output logic [3:0]  dmem_be_o,
   input  logic        dmem_ack_i,
   input  logic [31:0] dmem_rdata_i
);

   lsu_state_t  state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  be_q, be_d;
   logic        we_q, we_d;
   logic [4:0]  rd_q, rd_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [1:0]  addr_lo_q, addr_lo_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;

   logic        accept;
   logic        legal;
   logic [3:0]  be_req;
   logic [31:0] wdata_lane;
   logic [31:0] load_data;

   lsu_align u_align (
      .req_is_load    (mem_read_i),
      .req_funct3     (funct3_i),
      .req_addr_lo    (addr_i[1:0]),
      .req_wdata      (wdata_i),
      .req_legal      (legal),
      .req_be         (be_req),
      .req_wdata_lane (wdata_lane),
      .rsp_is_load    (~we_q),
      .rsp_funct3     (funct3_q),
      .rsp_addr_lo    (addr_lo_q),
      .rsp_rdata      (dmem_rdata_i),
      .rsp_data       (load_data)
   );

   assign accept = (state_q == IDLE) & valid_i & (mem_read_i | mem_write_i);

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      be_d      = be_q;
      we_d      = we_q;
      rd_d      = rd_q;
      funct3_d  = funct3_q;
      addr_lo_d = addr_lo_q;
      rdata_d   = rdata_q;
      err_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (legal) begin
                  state_d   = BUSY;
                  addr_d    = {addr_i[31:2], 2'b00};
                  wdata_d   = wdata_lane;
                  be_d      = be_req;
                  we_d      = ~mem_read_i;
                  rd_d      = rd_i;
                  funct3_d  = funct3_i;
                  addr_lo_d = addr_i[1:0];
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         BUSY: begin
            if (dmem_ack_i) begin
               state_d = DONE;
               rdata_d = load_data;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         be_q      <= '0;
         we_q      <= 1'b0;
         rd_q      <= '0;
         funct3_q  <= '0;
         addr_lo_q <= '0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         be_q      <= be_d;
         we_q      <= we_d;
         rd_q      <= rd_d;
         funct3_q  <= funct3_d;
         addr_lo_q <= addr_lo_d;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
      end
   end

   assign stall_o      = (accept & legal) | (state_q == BUSY);
   assign done_o       = (state_q == DONE);
   assign dmem_req_o   = (state_q == BUSY);
   assign rdata_o      = rdata_q;
   assign rd_o         = rd_q;
   assign err_o        = err_q;
   assign dmem_we_o    = we_q;
   assign dmem_addr_o  = addr_q;
   assign dmem_wdata_o = wdata_q;
   assign dmem_be_o    = be_q;

endmodule
